// File: rtl/tetris_pkg.sv
// Shared definitions for the piece rasteriser: grid defaults, rasteriser FSM
// states, coordinate typedefs and a helper sizing the signed cell arithmetic.
package tetris_pkg;

    localparam int GRID_W_DEF = 8;
    localparam int GRID_H_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RASTER = 2'd1,
        DONE   = 2'd2
    } rast_state_t;

    typedef logic [$clog2(GRID_W_DEF)-1:0] col_t;
    typedef logic [$clog2(GRID_H_DEF)-1:0] row_t;

    // Signed width able to hold origin + offset on either axis without wrap.
    function automatic int coord_width(input int xw, input int yw, input int ow);
        int m;
        m = (xw > yw) ? xw : yw;
        m = (m > ow) ? m : ow;
        return m + 2;
    endfunction

endpackage

// File: rtl/grid_cell_decoder.sv
// Combinational decoder: maps one signed absolute cell coordinate to a one-hot
// grid mask plus an in-bounds flag. Out-of-grid coordinates give an all-zero
// mask, so a cell never wraps into a neighbouring row or column.
module grid_cell_decoder #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int CW     = 5
) (
    input  logic signed [CW-1:0]            ax,
    input  logic signed [CW-1:0]            ay,
    output logic        [GRID_H*GRID_W-1:0] mask,
    output logic                            in_bounds
);

    localparam logic signed [CW-1:0] W_LIM = CW'(GRID_W);
    localparam logic signed [CW-1:0] H_LIM = CW'(GRID_H);

    // Bounds test and one-hot expansion of the current cell.
    always_comb begin
        in_bounds = !ax[CW-1] && !ay[CW-1] && (ax < W_LIM) && (ay < H_LIM);
        mask      = '0;
        for (int y = 0; y < GRID_H; y++) begin
            for (int x = 0; x < GRID_W; x++) begin
                mask[y*GRID_W+x] = in_bounds && (ax == CW'(x)) && (ay == CW'(y));
            end
        end
    end

endmodule

// File: rtl/piece_rasterizer.sv
// Sequential piece rasteriser: accepts a piece (origin + CELLS signed offsets),
// rasterises one cell per cycle into a registered one-hot occupancy matrix and
// flags out-of-bounds cells. Board collision detection (and the `board` port)
// is built only when PIECE_RASTER_COLLIDE_EN is defined; otherwise collide
// stays 0.
module piece_rasterizer
    import tetris_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int CELLS  = 4,
    parameter int OW     = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(GRID_W)-1:0]     in_org_x,
    input  logic [$clog2(GRID_H)-1:0]     in_org_y,
    input  logic [CELLS*OW-1:0]           in_dx,
    input  logic [CELLS*OW-1:0]           in_dy,
`ifdef PIECE_RASTER_COLLIDE_EN
    input  logic [GRID_H*GRID_W-1:0]      board,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [GRID_H*GRID_W-1:0]      matrix_out,
    output logic                          oob,
    output logic                          collide
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int CW = coord_width(XW, YW, OW);
    localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int N  = GRID_H * GRID_W;

    rast_state_t            state_r;
    logic [IW-1:0]          idx_r;
    logic [XW-1:0]          org_x_r;
    logic [YW-1:0]          org_y_r;
    logic [CELLS*OW-1:0]    dx_r;
    logic [CELLS*OW-1:0]    dy_r;
    logic [N-1:0]           matrix_r;
    logic                   oob_r;
    logic                   collide_r;
    logic                   out_valid_r;
    logic                   in_ready_r;

    logic signed [OW-1:0]   dx_cur_s;
    logic signed [OW-1:0]   dy_cur_s;
    logic signed [CW-1:0]   ax_s;
    logic signed [CW-1:0]   ay_s;
    logic [N-1:0]           cell_mask_s;
    logic                   in_bounds_s;
    logic                   hit_s;

    // Absolute coordinate of the cell selected by idx, widened so nothing wraps.
    always_comb begin
        dx_cur_s = dx_r[idx_r*OW +: OW];
        dy_cur_s = dy_r[idx_r*OW +: OW];
        ax_s     = $signed({{(CW-XW){1'b0}}, org_x_r}) + $signed({{(CW-OW){dx_cur_s[OW-1]}}, dx_cur_s});
        ay_s     = $signed({{(CW-YW){1'b0}}, org_y_r}) + $signed({{(CW-OW){dy_cur_s[OW-1]}}, dy_cur_s});
    end

    grid_cell_decoder #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .CW     (CW)
    ) u_decoder (
        .ax        (ax_s),
        .ay        (ay_s),
        .mask      (cell_mask_s),
        .in_bounds (in_bounds_s)
    );

    // Board overlap of the current cell; the mask is zero for out-of-grid cells.
    always_comb begin
`ifdef PIECE_RASTER_COLLIDE_EN
        hit_s = |(cell_mask_s & board);
`else
        hit_s = 1'b0;
`endif
    end

    // Rasteriser FSM: capture, per-cell accumulate, hold result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            org_x_r     <= '0;
            org_y_r     <= '0;
            dx_r        <= '0;
            dy_r        <= '0;
            matrix_r    <= '0;
            oob_r       <= 1'b0;
            collide_r   <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        org_x_r    <= in_org_x;
                        org_y_r    <= in_org_y;
                        dx_r       <= in_dx;
                        dy_r       <= in_dy;
                        matrix_r   <= '0;
                        oob_r      <= 1'b0;
                        collide_r  <= 1'b0;
                        idx_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RASTER;
                    end
                end
                RASTER: begin
                    matrix_r  <= matrix_r | cell_mask_s;
                    oob_r     <= oob_r | !in_bounds_s;
                    collide_r <= collide_r | hit_s;
                    if (idx_r == IW'(CELLS-1)) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign matrix_out = matrix_r;
    assign oob        = oob_r;
    assign collide    = collide_r;

endmodule

// File: tb/tb_piece_rasterizer.sv
// Self-checking bench for piece_rasterizer: expected results come from an
// independent integer model, queued at accept and compared at out_valid.
module tb_piece_rasterizer;

    localparam int GW    = 8;
    localparam int GH    = 8;
    localparam int CELLS = 4;
    localparam int OW    = 3;
    localparam int N     = GW * GH;
    localparam int DW    = CELLS * OW;

    typedef int offs_t [CELLS];
    typedef struct {
        logic [N-1:0] mat;
        logic         oob;
        logic         col;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_org_x = 3'd0;
    logic [2:0]    in_org_y = 3'd0;
    logic [DW-1:0] in_dx = '0;
    logic [DW-1:0] in_dy = '0;
    logic [N-1:0]  board_v = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  matrix_out;
    logic          oob;
    logic          collide;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    piece_rasterizer #(
        .GRID_W (GW),
        .GRID_H (GH),
        .CELLS  (CELLS),
        .OW     (OW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_org_x   (in_org_x),
        .in_org_y   (in_org_y),
        .in_dx      (in_dx),
        .in_dy      (in_dy),
`ifdef PIECE_RASTER_COLLIDE_EN
        .board      (board_v),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .matrix_out (matrix_out),
        .oob        (oob),
        .collide    (collide)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int ox, input int oy, input offs_t dxs, input offs_t dys,
                                   input logic [N-1:0] brd);
        exp_t e;
        int   ax;
        int   ay;
        e.mat = '0;
        e.oob = 1'b0;
        e.col = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            ax = ox + dxs[i];
            ay = oy + dys[i];
            if (ax >= 0 && ax < GW && ay >= 0 && ay < GH) begin
                e.mat[ay*GW+ax] = 1'b1;
`ifdef PIECE_RASTER_COLLIDE_EN
                if (brd[ay*GW+ax]) e.col = 1'b1;
`endif
            end else begin
                e.oob = 1'b1;
            end
        end
        if (brd === 'x) e.col = 1'b0;
        return e;
    endfunction

    // Present inputs for a piece without waiting for acceptance.
    task automatic present(input int ox, input int oy, input offs_t dxs, input offs_t dys);
        logic [DW-1:0] px;
        logic [DW-1:0] py;
        for (int i = 0; i < CELLS; i++) begin
            px[i*OW +: OW] = OW'(dxs[i]);
            py[i*OW +: OW] = OW'(dys[i]);
        end
        in_org_x = 3'(ox);
        in_org_y = 3'(oy);
        in_dx    = px;
        in_dy    = py;
        in_valid = 1'b1;
        sb_q.push_back(model(ox, oy, dxs, dys, board_v));
    endtask

    // Drive a piece and return 1 time unit after its accept edge.
    task automatic send(input int ox, input int oy, input offs_t dxs, input offs_t dys);
        int w;
        @(negedge clk);
        present(ox, oy, dxs, dys);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", 64'(w < 50), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_dx    = DW'($urandom());
        in_dy    = DW'($urandom());
    endtask

    // Wait for out_valid (bounded), compare against the scoreboard head.
    task automatic wait_result(input string tag, output logic [N-1:0] mat_o);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(CELLS));
        mat_o = matrix_out;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_matrix"}, 64'(matrix_out), 64'(e.mat));
            check({tag, "_oob"}, 64'(oob), 64'(e.oob));
            check({tag, "_collide"}, 64'(collide), 64'(e.col));
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_outv_fall"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_piece(input string tag, input int ox, input int oy, input offs_t dxs,
                             input offs_t dys, output logic [N-1:0] mat_o);
        send(ox, oy, dxs, dys);
        wait_result(tag, mat_o);
        handshake(tag);
    endtask

    initial begin
        logic [N-1:0] m;
        logic [N-1:0] held;
        logic         held_oob;
        offs_t        dxs;
        offs_t        dys;

        // Reset state, sampled during and just after reset.
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_matrix", 64'(matrix_out), 64'd0);
        check("rst_oob", 64'(oob), 64'd0);
        check("rst_collide", 64'(collide), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // O-piece at (3,3).
        board_v = '0;
        board_v[3*GW+3] = 1'b1;
        dxs = '{0, 1, 0, 1};
        dys = '{0, 0, 1, 1};
        run_piece("opiece", 3, 3, dxs, dys, m);
        check("opiece_row3", 64'(m[3*GW +: GW]), 64'h18);
        check("opiece_row4", 64'(m[4*GW +: GW]), 64'h18);
        check("opiece_others", 64'(m & ~(64'h18 << 24) & ~(64'h18 << 32)), 64'd0);

        // Same piece away from the occupied board cell.
        run_piece("opiece_55", 5, 5, dxs, dys, m);

        // Right-edge overflow.
        dxs = '{0, 1, -1, 0};
        dys = '{0, 0, 0, 1};
        run_piece("redge", 7, 0, dxs, dys, m);
        check("redge_row0", 64'(m[0 +: GW]), 64'hC0);
        check("redge_row1", 64'(m[GW +: GW]), 64'h80);
        check("redge_oob", 64'(oob), 64'd1);
        check("redge_no_wrap", 64'(m[1*GW+0]), 64'd0);

        // Negative offset staying in grid; duplicates OR silently.
        dxs = '{-1, -1, -1, -1};
        dys = '{0, 0, 0, 0};
        run_piece("neg_in", 1, 5, dxs, dys, m);
        check("neg_in_bit", 64'(m[5*GW+0]), 64'd1);
        check("neg_in_oob", 64'(oob), 64'd0);

        // Negative offset leaving the grid on the left.
        dxs = '{-1, 0, 0, 0};
        run_piece("neg_out", 0, 5, dxs, dys, m);
        check("neg_out_oob", 64'(oob), 64'd1);
        check("neg_out_no_wrap", 64'(m[4*GW+7]), 64'd0);

        // Backpressure: hold result while a second piece waits.
        dxs = '{0, 1, 2, 1};
        dys = '{0, 0, 0, 1};
        send(2, 2, dxs, dys);
        wait_result("bp_a", held);
        held_oob = oob;
        dxs = '{0, 0, 0, -1};
        dys = '{0, 1, 2, 1};
        present(4, 6, dxs, dys);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_outv_hold", 64'(out_valid), 64'd1);
            check("bp_matrix_hold", 64'(matrix_out), 64'(held));
            check("bp_oob_hold", 64'(oob), 64'(held_oob));
            check("bp_ready_low", 64'(in_ready), 64'd0);
        end
        handshake("bp_a");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_b_accepted", 64'(in_ready), 64'd0);
        wait_result("bp_b", m);
        handshake("bp_b");

        // Reset during RASTER discards the piece.
        dxs = '{0, 1, 2, 3};
        dys = '{0, 0, 0, 0};
        send(1, 1, dxs, dys);
        @(posedge clk);
        #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_matrix", 64'(matrix_out), 64'd0);
        check("mrst_oob", 64'(oob), 64'd0);
        check("mrst_collide", 64'(collide), 64'd0);
        void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        dxs = '{0, 1, 0, -1};
        dys = '{0, 0, 1, 1};
        run_piece("post_rst", 6, 6, dxs, dys, m);

        // Random pieces and boards.
        for (int k = 0; k < 8; k++) begin
            board_v = {32'($urandom()), 32'($urandom())};
            for (int i = 0; i < CELLS; i++) begin
                dxs[i] = int'($urandom_range(7)) - 4;
                dys[i] = int'($urandom_range(7)) - 4;
            end
            run_piece("rand", int'($urandom_range(7)), int'($urandom_range(7)), dxs, dys, m);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
